// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN feature-map datapath.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 32;
    localparam int CNN_FRAC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } beat_flags_t;

    localparam int FLAG_WIDTH = $bits(beat_flags_t);

    // Width needed to index/count v things, never below one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with occupancy count; write and read in the
// same cycle are both performed. Writes to a full FIFO without a read are dropped.
module stream_fifo
    import cnn_pkg::*;
#(
    parameter int WIDTH = CNN_DATA_WIDTH + FLAG_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              wr_en_i,
    input  logic [WIDTH-1:0]                  wr_data_i,
    input  logic                              rd_en_i,
    output logic [WIDTH-1:0]                  rd_data_o,
    output logic                              valid_o,
    output logic [clog2_min1(DEPTH+1)-1:0]    count_o
);

    localparam int PW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    // Pointer and occupancy update; a full FIFO still accepts a write when it is also read.
    always_comb begin
        do_rd    = rd_en_i && (count_q != '0);
        do_wr    = wr_en_i && ((count_q != FULL_CNT) || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign valid_o   = (count_q != '0);
    assign count_o   = count_q;

endmodule

// File: rtl/feature_map_stream_reader.sv
// Reads a stored feature map from a synchronous-read RAM and streams it in
// raster order with sof/eol/eof markers. Reads are credit-limited so the
// output FIFO can always absorb every in-flight RAM word.
// Optional: define FMAP_READER_CHECKSUM_EN to add checksum_o (sum of all
// handshaken beats, cleared on each accepted start).
module feature_map_stream_reader
    import cnn_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int N_ROWS     = 53,
    parameter int N_COLS     = 79,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o
`ifdef FMAP_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    localparam int TOTAL = N_ROWS * N_COLS;
    localparam int RW    = clog2_min1(N_ROWS);
    localparam int CLW   = clog2_min1(N_COLS);
    localparam int CW    = clog2_min1(FIFO_DEPTH + 1);
    localparam int FW    = DATA_WIDTH + FLAG_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [RW-1:0]         LAST_ROW  = RW'(N_ROWS - 1);
    localparam logic [CLW-1:0]        LAST_COL  = CLW'(N_COLS - 1);
    localparam logic [CW:0]           CREDITS   = (CW + 1)'(FIFO_DEPTH);

    rd_state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]         idx_q, idx_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [CLW-1:0]                col_q, col_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [RD_LATENCY:0]           pv_q, pv_d;
    beat_flags_t [RD_LATENCY:0]    pf_q, pf_d;
    logic [CW-1:0]                 inflight_q, inflight_d;

    logic                          issue;
    logic                          start_ok;
    logic                          credit_ok;
    logic                          fifo_wr;
    logic                          pop;
    beat_flags_t                   issue_flags;
    beat_flags_t                   head_flags;
    logic [FW-1:0]                 fifo_wr_data;
    logic [FW-1:0]                 fifo_rd_data;
    logic                          fifo_valid;
    logic [CW-1:0]                 fifo_count;

    // Position markers of the pixel about to be read.
    always_comb begin
        issue_flags     = '0;
        issue_flags.sof = (row_q == '0) && (col_q == '0);
        issue_flags.eol = (col_q == LAST_COL);
        issue_flags.eof = (col_q == LAST_COL) && (row_q == LAST_ROW);
    end

    // FSM next state, read issue under the credit rule, and raster counters.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        addr_d    = addr_q;
        issue     = 1'b0;
        start_ok  = (state_q == ST_IDLE) && start_i;
        credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDITS;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = idx_q;
                    idx_d  = idx_q + 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (idx_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                        row_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // Finish as soon as the last beat leaves, so done_o follows its handshake directly.
                if ((inflight_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay line carrying read-valid and flags until the RAM word arrives; tracks reads in flight.
    always_comb begin
        pv_d       = {pv_q[RD_LATENCY-1:0], issue};
        pf_d       = {pf_q[RD_LATENCY-1:0], issue_flags};
        fifo_wr    = pv_q[RD_LATENCY];
        pop        = fifo_valid && m_ready_i;
        inflight_d = inflight_q + CW'(issue) - CW'(fifo_wr);
    end

    // Registers for FSM, counters, address and delay line; reset flushes everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            pv_q       <= '0;
            pf_q       <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            pv_q       <= pv_d;
            pf_q       <= pf_d;
            inflight_q <= inflight_d;
        end
    end

    assign fifo_wr_data = {pf_q[RD_LATENCY], ram_q_i};

    stream_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    assign head_flags      = fifo_rd_data[FW-1:DATA_WIDTH];
    assign m_data_o        = fifo_rd_data[DATA_WIDTH-1:0];
    assign m_valid_o       = fifo_valid;
    assign m_sof_o         = fifo_valid && head_flags.sof;
    assign m_eol_o         = fifo_valid && head_flags.eol;
    assign m_eof_o         = fifo_valid && head_flags.eof;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);
    assign ram_rdaddress_o = addr_q;

`ifdef FMAP_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    // Running modulo-2^DATA_WIDTH sum of delivered beats.
    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if (pop) begin
            checksum_d = checksum_q + m_data_o;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_feature_map_stream_reader.sv
// Scoreboard bench for feature_map_stream_reader on a 2x3 map.
module tb_feature_map_stream_reader;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int NR   = 2;
    localparam int NC   = 3;
    localparam int RL   = 1;
    localparam int FD   = 4;
    localparam int NPIX = NR * NC;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
`ifdef FMAP_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    logic [DW-1:0] mem [8];
    beat_t         sb[$];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    int unsigned   beats = 0;
    bit            expect_done = 1'b0;
    int            ready_mode = 0;

    always #5 clk = ~clk;

    feature_map_stream_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_ROWS     (NR),
        .N_COLS     (NC),
        .RD_LATENCY (RL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .ram_rdaddress_o (ram_addr),
        .ram_q_i         (ram_q),
        .m_data_o        (m_data),
        .m_valid_o       (m_valid),
        .m_ready_i       (m_ready),
        .m_sof_o         (m_sof),
        .m_eol_o         (m_eol),
        .m_eof_o         (m_eof)
`ifdef FMAP_READER_CHECKSUM_EN
        ,
        .checksum_o      (checksum)
`endif
    );

    // Synchronous-read RAM, one cycle latency, RAM[k] = k<<16.
    initial begin
        for (int k = 0; k < 8; k++) mem[k] = DW'(k) << 16;
    end
    always @(posedge clk) ram_q <= mem[ram_addr[2:0]];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        for (int k = 0; k < NPIX; k++) begin
            b.d   = DW'(k) << 16;
            b.sof = (k == 0);
            b.eol = ((k % NC) == NC - 1);
            b.eof = (k == NPIX - 1);
            sb.push_back(b);
        end
    endtask

    // Called at posedge+1; start is sampled by the next edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
`ifdef FMAP_READER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, 32'h000F0000);
`endif
        @(posedge clk); #1;
        check({tag, "_done_1cyc"}, done, 0);
    endtask

    // Ready pattern generator: 0 = always ready, 1 = toggle, 2 = hold low.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: head of stream must equal scoreboard head every valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (expect_done) begin
                check("done_pulse", done, 1);
                expect_done = 1'b0;
            end else if (done) begin
                check("done_spurious", done, 0);
            end
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check("extra_beat", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("beat_data", m_data, sb[0].d);
                    check("beat_sof", m_sof, sb[0].sof);
                    check("beat_eol", m_eol, sb[0].eol);
                    check("beat_eof", m_eof, sb[0].eof);
                    if (m_ready) begin
                        if (sb[0].eof) expect_done = 1'b1;
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int unsigned base;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_flags", {m_sof, m_eol, m_eof}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: full-rate frame, first valid three cycles after start is sampled.
        push_frame();
        pulse_start();
        check("t1_busy", busy, 1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("t1_valid_c%0d", c), m_valid, (c == 3) ? 1 : 0);
        end
        wait_done("t1");

        // T2: alternating ready.
        ready_mode = 1;
        push_frame();
        pulse_start();
        wait_done("t2");
        ready_mode = 0;
        @(posedge clk); #1;

        // T3: long stall; read issue must stop at FIFO_DEPTH outstanding reads.
        ready_mode = 2;
        @(posedge clk); #1;
        push_frame();
        pulse_start();
        repeat (20) @(posedge clk);
        #1;
        check("t3_addr_hold", ram_addr, FD - 1);
        check("t3_valid_held", m_valid, 1);
        ready_mode = 0;
        wait_done("t3");

        // T4: starts while busy are ignored; a later start replays from address 0.
        push_frame();
        pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t4_busy", busy, 1);
        wait_done("t4a");
        push_frame();
        pulse_start();
        wait_done("t4b");

        // T5: reset mid-frame, then a clean frame.
        push_frame();
        base = beats;
        pulse_start();
        n = 0;
        while (beats < base + 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_reached_beat3", (beats >= base + 3), 1);
        rst = 1'b1;
        sb.delete();
        expect_done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_valid", m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_addr", ram_addr, 0);
        push_frame();
        pulse_start();
        wait_done("t5b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
